uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding buffer feeding a start/data/parity/stop
// serialiser with a registered, idle-high serial line.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic       data_out,
  output logic       busy,
  output logic       done
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W     = (STOP_CLKS > 2) ? $clog2(STOP_CLKS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state, state_d;

  logic             buf_full, buf_full_d;
  logic [7:0]       buf_data, buf_data_d;
  logic [7:0]       shift_reg, shift_d;
  logic             parity_bit, parity_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic             data_out_d;
  logic             done_d;

  logic bit_end;
  logic stop_end;
  logic load;

  assign bit_end  = (cnt == BIT_LAST);
  assign stop_end = (cnt == STOP_LAST);
  // A frame is loaded whenever the FSM enters START, from IDLE or straight out of STOP.
  assign load     = (state_d == START) && (state != START);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: each combinational block assigns a default to every output first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (buf_full) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_idx == 3'd7)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (stop_end) state_d = buf_full ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_full_d = buf_full;
    buf_data_d = buf_data;
    shift_d    = shift_reg;
    parity_d   = parity_bit;
    cnt_d      = cnt;
    bit_idx_d  = bit_idx;
    data_out_d = 1'b1;
    done_d     = 1'b0;

    // The buffer is full whenever load is high, so accept and load never collide.
    if (load) begin
      buf_full_d = 1'b0;
      shift_d    = buf_data;
      parity_d   = (^buf_data) ^ (PARITY_ODD != 0);
    end else if (data_valid && !buf_full) begin
      buf_full_d = 1'b1;
      buf_data_d = data_in;
    end

    if ((state == IDLE) || (state_d != state) || ((state == DATA) && bit_end)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt + CNT_W'(1);
    end

    if (state != DATA) begin
      bit_idx_d = 3'd0;
    end else if (bit_end) begin
      bit_idx_d = bit_idx + 3'd1;
      shift_d   = shift_reg >> 1;
    end

    case (state_d)
      START:   data_out_d = 1'b0;
      DATA:    data_out_d = ((state == DATA) && bit_end) ? shift_reg[1] : shift_reg[0];
      PARITY:  data_out_d = parity_bit;
      default: data_out_d = 1'b1;
    endcase

    done_d = (state == STOP) && stop_end;
  end

  // NOTE: the datapath registers are reset as well as the control, so a
  // byte discarded by reset can never reappear on the line afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full   <= 1'b0;
      buf_data   <= 8'h00;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      data_out   <= 1'b1;
      done       <= 1'b0;
    end else begin
      buf_full   <= buf_full_d;
      buf_data   <= buf_data_d;
      shift_reg  <= shift_d;
      parity_bit <= parity_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      data_out   <= data_out_d;
      done       <= done_d;
    end
  end

  assign ready = !buf_full;
  assign busy  = (state != IDLE);

endmodule
